// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for the 5-stage MIPS core: PC enable plus enable/flush for the
// FD, DE, EM and MW latches, with load-use stall, halt drain, sticky halt and a stall counter.
module hazard_ctrl #(
  parameter int LU_BUBBLES   = 1,
  parameter int DRAIN_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ihit,
  input  logic             dreq,
  input  logic             dhit,
  input  logic             ex_memread,
  input  logic [4:0]       ex_rd,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             jump,
  input  logic             mispredict,
  input  logic             halt_mem,
  output logic             pc_en,
  output logic [3:0]       en,
  output logic [3:0]       flush,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    LUSTALL = 2'd1,
    DRAIN   = 2'd2,
    HALTED  = 2'd3
  } state_t;

  localparam logic [2:0]       LU_INIT    = 3'((LU_BUBBLES > 1) ? (LU_BUBBLES - 2) : 0);
  localparam logic [2:0]       DRAIN_INIT = 3'(DRAIN_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  state_t     state, state_n;
  logic [2:0] cnt, cnt_n;
  logic       lu;
  logic       dstall;
  logic       count_stall;

  assign lu = ex_memread && (ex_rd != 5'd0) &&
              ((id_use_rs && (id_rs == ex_rd)) || (id_use_rt && (id_rt == ex_rd)));

  // dreq/dhit: a data access is outstanding while dreq=1 and dhit=0; everything freezes until dhit.
  assign dstall = dreq && !dhit;

  assign dbg_state = state;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    pc_en   = 1'b1;
    en      = 4'b1111;
    flush   = 4'b0000;
    halted  = 1'b0;
    if (!nRST) begin
      pc_en = 1'b0;
      en    = 4'b0000;
    end else if (state == HALTED) begin
      pc_en  = 1'b0;
      en     = 4'b0000;
      halted = 1'b1;
    end else if (dstall) begin
      pc_en = 1'b0;
      en    = 4'b0000;
    end else if (state == DRAIN) begin
      pc_en = 1'b0;
      flush = 4'b0011;
      if (cnt == 3'd0) state_n = HALTED;
      else             cnt_n   = cnt - 3'd1;
    end else if (halt_mem) begin
      pc_en   = 1'b0;
      flush   = 4'b0011;
      state_n = DRAIN;
      cnt_n   = DRAIN_INIT;
    end else if (mispredict) begin
      flush   = 4'b0011;
      state_n = RUN;
      cnt_n   = 3'd0;
    end else if (jump) begin
      flush   = 4'b0001;
      state_n = RUN;
      cnt_n   = 3'd0;
    end else if (lu || (state == LUSTALL)) begin
      // Hold FD and the PC, push a bubble into DE so the load can reach MEM.
      pc_en = 1'b0;
      en    = 4'b1110;
      flush = 4'b0010;
      if (state == RUN) begin
        if (LU_BUBBLES > 1) begin
          state_n = LUSTALL;
          cnt_n   = LU_INIT;
        end
      end else if (cnt == 3'd0) begin
        state_n = RUN;
      end else begin
        cnt_n = cnt - 3'd1;
      end
    end else if (!ihit) begin
      pc_en = 1'b0;
      flush = 4'b0001;
    end
    count_stall = !pc_en && ((state == RUN) || (state == LUSTALL));
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= RUN;
      cnt   <= 3'd0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)                                     stall_cnt <= '0;
    else if (count_stall && (stall_cnt != CNT_MAX)) stall_cnt <= stall_cnt + 1'b1;
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl (LU_BUBBLES=3, DRAIN_CYCLES=2, CNT_W=4): decode vector table in RUN,
// then hand-written load-use, mispredict, data-stall, halt, saturation and async-reset sequences.
module tb_hazard_ctrl;

  localparam int CNT_W = 4;

  logic             CLK = 1'b0;
  logic             nRST;
  logic             ihit, dreq, dhit, ex_memread;
  logic [4:0]       ex_rd, id_rs, id_rt;
  logic             id_use_rs, id_use_rt, jump, mispredict, halt_mem;
  logic             pc_en;
  logic [3:0]       en, flush;
  logic             halted;
  logic [CNT_W-1:0] stall_cnt;
  logic [1:0]       dbg_state;

  hazard_ctrl #(.LU_BUBBLES(3), .DRAIN_CYCLES(2), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dreq(dreq), .dhit(dhit),
    .ex_memread(ex_memread), .ex_rd(ex_rd), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .jump(jump),
    .mispredict(mispredict), .halt_mem(halt_mem), .pc_en(pc_en), .en(en),
    .flush(flush), .halted(halted), .stall_cnt(stall_cnt), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 CLK = ~CLK;

  // output word {pc_en, en, flush, halted}
  localparam logic [9:0] W_RUN   = {1'b1, 4'b1111, 4'b0000, 1'b0};
  localparam logic [9:0] W_IMISS = {1'b0, 4'b1111, 4'b0001, 1'b0};
  localparam logic [9:0] W_JUMP  = {1'b1, 4'b1111, 4'b0001, 1'b0};
  localparam logic [9:0] W_MISP  = {1'b1, 4'b1111, 4'b0011, 1'b0};
  localparam logic [9:0] W_DSTL  = {1'b0, 4'b0000, 4'b0000, 1'b0};
  localparam logic [9:0] W_LU    = {1'b0, 4'b1110, 4'b0010, 1'b0};
  localparam logic [9:0] W_DRAIN = {1'b0, 4'b1111, 4'b0011, 1'b0};
  localparam logic [9:0] W_HALT  = {1'b0, 4'b0000, 4'b0000, 1'b1};

  typedef struct {
    logic       dreq, dhit, ihit, memread;
    logic [4:0] ex_rd, rs, rt;
    logic       use_rs, use_rt, jump, mis, halt;
    logic [9:0] exp;
    string      name;
  } vec_t;

  vec_t       vecs[$];
  logic [9:0] exp_q[$];
  int         n_checks = 0;
  int         n_fail   = 0;

  function automatic void add_vec(input logic dq, input logic dh, input logic ih, input logic mr,
                                  input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt,
                                  input logic urs, input logic urt, input logic jp, input logic ms,
                                  input logic hl, input logic [9:0] ex, input string nm);
    vec_t v;
    v.dreq = dq; v.dhit = dh; v.ihit = ih; v.memread = mr;
    v.ex_rd = rd; v.rs = rs; v.rt = rt; v.use_rs = urs; v.use_rt = urt;
    v.jump = jp; v.mis = ms; v.halt = hl; v.exp = ex; v.name = nm;
    vecs.push_back(v);
  endfunction

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // driver tasks
  task automatic idle();
    ihit = 1'b1; dreq = 1'b0; dhit = 1'b0; ex_memread = 1'b0;
    ex_rd = 5'd0; id_rs = 5'd0; id_rt = 5'd0; id_use_rs = 1'b0; id_use_rt = 1'b0;
    jump = 1'b0; mispredict = 1'b0; halt_mem = 1'b0;
  endtask

  task automatic set_lu();
    ex_memread = 1'b1; ex_rd = 5'd5; id_rs = 5'd5; id_use_rs = 1'b1;
  endtask

  // scoreboard: push expected word, sample at the falling edge, then advance past the next rising edge
  task automatic step(input logic [9:0] exp, input string name);
    logic [9:0] e;
    exp_q.push_back(exp);
    @(negedge CLK);
    if (exp_q.size() == 0) begin
      n_checks++; n_fail++;
      $display("FAIL %s: scoreboard queue empty", name);
    end else begin
      e = exp_q.pop_front();
      check(name, {22'd0, pc_en, en, flush, halted}, {22'd0, e});
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset(input string name);
    nRST = 1'b0;
    #1;
    check({name, "_outs"}, {22'd0, pc_en, en, flush, halted}, 32'd0);
    check({name, "_cnt"}, {28'd0, stall_cnt}, 32'd0);
    check({name, "_state"}, {30'd0, dbg_state}, 32'd0);
    @(posedge CLK);
    @(posedge CLK);
    #1;
    nRST = 1'b1;
  endtask

  initial begin
    idle();
    nRST = 1'b0;
    do_reset("reset0");

    // decode table, every row leaves the FSM in RUN
    //      dq   dh   ih   mr   rd    rs    rt  urs  urt  jp   ms   hl
    add_vec(0, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, W_RUN,   "idle");
    add_vec(0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, W_IMISS, "imiss");
    add_vec(0, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 0, W_JUMP,  "jump");
    add_vec(0, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0, W_MISP,  "misp");
    add_vec(0, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 1, 0, W_MISP,  "misp_jump");
    add_vec(1, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, W_DSTL,  "dstall");
    add_vec(1, 1, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, W_RUN,   "dhit");
    add_vec(1, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 1, W_DSTL,  "dstall_halt");
    add_vec(0, 0, 1, 1, 5'd0, 5'd0, 5'd0, 1, 1, 0, 0, 0, W_RUN,   "lu_rd0");
    add_vec(0, 0, 1, 1, 5'd5, 5'd5, 5'd5, 0, 0, 0, 0, 0, W_RUN,   "lu_nouse");
    add_vec(0, 0, 1, 1, 5'd5, 5'd0, 5'd5, 0, 1, 0, 1, 0, W_MISP,  "lu_misp");
    add_vec(0, 0, 1, 0, 5'd5, 5'd5, 5'd5, 1, 1, 0, 0, 0, W_RUN,   "nonload");
    add_vec(1, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0, W_DSTL,  "dstall_misp");
    add_vec(0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 0, W_JUMP,  "imiss_jump");
    add_vec(0, 0, 1, 1, 5'd7, 5'd3, 5'd9, 1, 1, 0, 0, 0, W_RUN,   "lu_nomatch");

    foreach (vecs[i]) begin
      dreq = vecs[i].dreq; dhit = vecs[i].dhit; ihit = vecs[i].ihit;
      ex_memread = vecs[i].memread; ex_rd = vecs[i].ex_rd;
      id_rs = vecs[i].rs; id_rt = vecs[i].rt;
      id_use_rs = vecs[i].use_rs; id_use_rt = vecs[i].use_rt;
      jump = vecs[i].jump; mispredict = vecs[i].mis; halt_mem = vecs[i].halt;
      step(vecs[i].exp, vecs[i].name);
    end
    idle();
    check("table_stall_cnt", {28'd0, stall_cnt}, 32'd4);
    check("table_state", {30'd0, dbg_state}, 32'd0);

    // load-use costs exactly three bubbles
    do_reset("reset_lu");
    set_lu();
    step(W_LU, "lu_c1");
    idle();
    step(W_LU, "lu_c2");
    step(W_LU, "lu_c3");
    step(W_RUN, "lu_done");
    check("lu_stall_cnt", {28'd0, stall_cnt}, 32'd3);

    // mispredict in the second LUSTALL cycle cancels the stall
    do_reset("reset_misp");
    set_lu();
    step(W_LU, "lum_c1");
    idle();
    mispredict = 1'b1;
    step(W_MISP, "lum_misp");
    mispredict = 1'b0;
    step(W_RUN, "lum_run1");
    step(W_RUN, "lum_run2");
    check("lum_stall_cnt", {28'd0, stall_cnt}, 32'd1);

    // data stall inside LUSTALL freezes the bubble count
    do_reset("reset_lud");
    set_lu();
    step(W_LU, "lud_c1");
    idle();
    dreq = 1'b1;
    for (int k = 0; k < 4; k++) step(W_DSTL, "lud_dstall");
    dreq = 1'b0;
    step(W_LU, "lud_c2");
    step(W_LU, "lud_c3");
    step(W_RUN, "lud_done");
    check("lud_stall_cnt", {28'd0, stall_cnt}, 32'd7);

    // halt: detect cycle, two drain cycles with a data stall between, then halted
    do_reset("reset_halt");
    halt_mem = 1'b1;
    step(W_DRAIN, "halt_detect");
    halt_mem = 1'b0;
    step(W_DRAIN, "halt_drain1");
    dreq = 1'b1;
    step(W_DSTL, "halt_dstall");
    dreq = 1'b0;
    step(W_DRAIN, "halt_drain2");
    step(W_HALT, "halt_c4");
    jump = 1'b1;
    step(W_HALT, "halt_jump");
    jump = 1'b0; mispredict = 1'b1; ihit = 1'b0;
    step(W_HALT, "halt_misp");
    idle();
    set_lu();
    step(W_HALT, "halt_lu");
    idle();
    check("halt_stall_cnt", {28'd0, stall_cnt}, 32'd1);

    // stall counter saturates at 15
    do_reset("reset_sat");
    ihit = 1'b0;
    for (int k = 0; k < 20; k++) step(W_IMISS, "sat_imiss");
    check("sat_stall_cnt", {28'd0, stall_cnt}, 32'd15);
    #2;
    do_reset("reset_async_mid");
    idle();

    // async reset in the middle of LUSTALL aborts it
    set_lu();
    step(W_LU, "lur_c1");
    idle();
    check("lur_state", {30'd0, dbg_state}, 32'd1);
    #3;
    do_reset("reset_async_lu");
    step(W_RUN, "lur_after");

    if (exp_q.size() != 0) begin
      n_checks++; n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, 0 required", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time %0t reached, end of test required", $time);
    $fatal(1, "watchdog");
  end

endmodule
